// File: rtl/elastic_pipe_register.sv
// Elastic delay line: DEPTH valid/data stages with a valid/ready handshake at both ends,
// local stalling under backpressure, synchronous flush and a registered occupancy count.
module elastic_pipe_register #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   r;
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] drop;
  logic             flush;
  logic             push;
  logic             pop;

  // rst_n is active-high here; reset and clear share the same flush path
  assign flush = rst_n | clear;

  // r[i] = out_ready OR any stage at or beyond i is empty; flattened to avoid a
  // combinational self-reference on the r vector
  always_comb begin
    r = '0;
    r[DEPTH] = out_ready;
    for (int i = 0; i < DEPTH; i++) begin
      r[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!v[j]) r[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ld = '0;
    drop = '0;
    ld[0] = in_valid && r[0];
    for (int i = 1; i < DEPTH; i++) ld[i] = v[i-1] && r[i];
    for (int i = 0; i < DEPTH; i++) drop[i] = r[i+1];
  end

  assign in_ready  = r[0] && !flush;
  assign out_valid = v[DEPTH-1] && !flush;
  assign out_data  = d[DEPTH-1];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (flush) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld[i]) v[i] <= 1'b1;
        else if (drop[i]) v[i] <= 1'b0;
      end
      if (ld[0]) d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (ld[i]) d[i] <= d[i-1];
      end
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: doc/elastic_pipe_register.md
Name: elastic_pipe_register

Overview:
- Parametrised successor to the plain enable/clear register used in the sequential multiplier datapath.
- A chain of DEPTH data registers, each with a valid bit, and a valid/ready handshake at both ends.
- Stalls stages locally under backpressure, supports a synchronous flush, and reports occupancy.
- Placement: between multiplier front-end operand capture and the iterative core, and anywhere a stallable, flushable delay line is needed.

Parameters:
- WIDTH, 16, data bits per stage.
- DEPTH, 2, number of register stages; legal range 1..16.
- CW, $clog2(DEPTH+1), width of the count output; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-high (1 = reset), sampled on clk rising edge.
- clear  in  1  synchronous flush; empties all stages.
- in_valid  in  1  upstream has data on in_data.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage DEPTH-1 holds valid data.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  payload of stage DEPTH-1.
- count  out  CW  number of stages with valid=1, range 0..DEPTH.

Behaviour:
- State: v[i] (valid) and d[i] (data) for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- Ready chain (combinational): r[DEPTH] = out_ready; r[i] = !v[i] || r[i+1]; in_ready = r[0] && !clear.
- out_valid = v[DEPTH-1] && !clear; out_data = d[DEPTH-1], driven regardless of valid.
- Input transfer: in_valid && in_ready.
- Stage transfer i-1 -> i: v[i-1] && r[i].
- Output transfer: out_valid && out_ready.
- Per-stage update when not in reset or clear:
  - If the upstream source (in_valid for stage 0, v[i-1] for stage i) is valid and r[i]=1: load d[i] and set v[i]=1.
  - Else if r[i+1]=1: set v[i]=0 and hold d[i].
  - Else: hold both.
- Data registers load only on transfer; they are never cleared except by rst_n or clear.
- Latency: a word accepted in cycle N appears on out_valid in cycle N+DEPTH when unstalled.
- Throughput: 1 word/cycle sustained, including while the pipe is full, if out_ready=1.
- Order: strict FIFO; no word is dropped or duplicated.
- Bubbles: an empty stage does not stall upstream, so bubbles collapse under backpressure.
- in_valid/in_data stability: the block does not rely on it; it samples only on transfer.
- count: registered. Incremented on input transfer only, decremented on output transfer only, unchanged when both or neither occur. Always equals the popcount of v[].
- Full: count == DEPTH and out_ready=0 gives in_ready=0. Full with out_ready=1 gives in_ready=1; pop and push occur in the same cycle and count stays DEPTH.
- Empty: count == 0 gives out_valid=0; in_ready=1 regardless of out_ready.
- clear=1:
  - in_ready and out_valid are forced 0, so no handshake completes in that cycle.
  - Next edge: all v[i]=0, all d[i]=0, count=0.
- Priority: rst_n > clear > transfers.
- Reset (rst_n=1), including mid-operation: same effect as clear, and in_ready/out_valid are forced 0 while asserted. After rst_n deasserts: in_ready=1, out_valid=0, out_data=0, count=0.
- DEPTH=1: single stage; in_ready = !v[0] || out_ready.

Test Plan:
- Reset: DEPTH=3, rst_n=1 for 2 cycles, then released -> out_valid=0, out_data=16'h0000, count=0, in_ready=1.
- Streaming: DEPTH=3, out_ready=1, push 16'h0001..16'h0005 back-to-back from cycle 0 -> out_valid first high at cycle 3 with 16'h0001, then one word per cycle in order; count holds 3 during steady state.
- Backpressure: DEPTH=3, out_ready=0, push 16'hA000..16'hA003 -> three accepted, in_ready=0 with 16'hA003 pending, count=3. Raise out_ready -> outputs A000, A001, A002, A003 in order, with no gap once flowing.
- Full push+pop: pipe full, out_ready=1 and in_valid=1 for 4 cycles -> each cycle one pop and one push, count stays 3, in_ready stays 1.
- Clear mid-stream: two words in flight, clear=1 for 1 cycle with in_valid=1 -> in_ready=0 and out_valid=0 in that cycle; next cycle count=0, out_data=0, and the offered word was not accepted.
- Bubble collapse: DEPTH=4, push at cycles 0 and 2, out_ready=0 -> both words compact into stages 3 and 2 and count=2. Release -> they emerge on consecutive cycles.
